// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and rotate helper for the round sequencer.
package sha1_pkg;

  localparam int ROUNDS = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] IV_H0 = 32'h67452301;
  localparam logic [31:0] IV_H1 = 32'hEFCDAB89;
  localparam logic [31:0] IV_H2 = 32'h98BADCFE;
  localparam logic [31:0] IV_H3 = 32'h10325476;
  localparam logic [31:0] IV_H4 = 32'hC3D2E1F0;

  // Packed so that IV[i] is H_i and the whole vector matches the digest layout.
  localparam logic [4:0][31:0] IV = {IV_H4, IV_H3, IV_H2, IV_H1, IV_H0};

  localparam logic [31:0] K_00_19 = 32'h5A827999;
  localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
  localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
  localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sha1_round_seq_if.sv
// Command/status bundle between the register front-end and the SHA-1 round sequencer.
interface sha1_round_seq_if;
  logic             clr_i;
  logic             start_i;
  logic             chain_i;
  logic [511:0]     msg_i;
  logic [159:0]     digest_o;
  logic             busy_o;
  logic             done_o;
  logic             panic_o;
  logic [6:0]       round_idx_o;

  modport master (
    output clr_i, start_i, chain_i, msg_i,
    input  digest_o, busy_o, done_o, panic_o, round_idx_o
  );

  modport slave (
    input  clr_i, start_i, chain_i, msg_i,
    output digest_o, busy_o, done_o, panic_o, round_idx_o
  );
endinterface

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: selects f_t and K_t from t and produces the next A-E.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] w_i,
  input  logic [6:0]  t_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o
);

  logic [31:0] f;
  logic [31:0] k;

  always_comb begin
    f = b_i ^ c_i ^ d_i;
    k = K_60_79;
    if (t_i < 7'd20) begin
      f = (b_i & c_i) | (~b_i & d_i);
      k = K_00_19;
    end else if (t_i < 7'd40) begin
      k = K_20_39;
    end else if (t_i < 7'd60) begin
      f = (b_i & c_i) | (b_i & d_i) | (c_i & d_i);
      k = K_40_59;
    end
  end

  assign a_o = rotl(a_i, 5) + f + e_i + k + w_i;
  assign b_o = a_i;
  assign c_o = rotl(b_i, 30);
  assign d_o = c_i;
  assign e_o = d_i;

endmodule

// File: rtl/sha1_round_seq.sv
// SHA-1 compression sequencer: latches a block, runs 80 rounds one per clock, folds into H.
module sha1_round_seq
  import sha1_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             reset_n,
  sha1_round_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [6:0]        round_q, round_d;
  logic [15:0][31:0] w_q, w_d;
  logic [31:0]       a_q, b_q, c_q, d_q, e_q;
  logic [31:0]       a_d, b_d, c_d, d_d, e_d;
  logic [4:0][31:0]  h_q, h_d;
  logic              panic_q, panic_d;

  logic [31:0]       a_nxt, b_nxt, c_nxt, d_nxt, e_nxt;
  logic [4:0][31:0]  h_sel;

  sha1_round u_round (
    .a_i (a_q), .b_i (b_q), .c_i (c_q), .d_i (d_q), .e_i (e_q),
    .w_i (w_q[0]), .t_i (round_q),
    .a_o (a_nxt), .b_o (b_nxt), .c_o (c_nxt), .d_o (d_nxt), .e_o (e_nxt)
  );

  assign h_sel = bus.chain_i ? h_q : IV;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    w_d     = w_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    h_d     = h_q;
    panic_d = panic_q;

    if (bus.clr_i) begin
      state_d = ST_IDLE;
      h_d     = IV;
      round_d = '0;
      panic_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            w_d     = bus.msg_i;
            h_d     = h_sel;
            a_d     = h_sel[0];
            b_d     = h_sel[1];
            c_d     = h_sel[2];
            d_d     = h_sel[3];
            e_d     = h_sel[4];
            round_d = '0;
            state_d = ST_ROUND;
          end
        end
        ST_ROUND: begin
          a_d = a_nxt;
          b_d = b_nxt;
          c_d = c_nxt;
          d_d = d_nxt;
          e_d = e_nxt;
          // Rolling 16-word window: w[0] is always W[t] for the round being executed.
          w_d = {rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1), w_q[15:1]};
          if (round_q == 7'(ROUNDS - 1)) state_d = ST_FINAL;
          else                           round_d = round_q + 7'd1;
          if (bus.start_i) panic_d = 1'b1;
        end
        ST_FINAL: begin
          h_d[0]  = h_q[0] + a_q;
          h_d[1]  = h_q[1] + b_q;
          h_d[2]  = h_q[2] + c_q;
          h_d[3]  = h_q[3] + d_q;
          h_d[4]  = h_q[4] + e_q;
          state_d = ST_DONE;
          if (bus.start_i) panic_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      w_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      h_q     <= IV;
      panic_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      w_q     <= w_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      h_q     <= h_d;
      panic_q <= panic_d;
    end
  end

  assign bus.digest_o    = h_q;
  assign bus.busy_o      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.panic_o     = panic_q;
  assign bus.round_idx_o = round_q;

endmodule

// File: tb/tb_sha1_round_seq.sv
// Directed plus randomized bench for sha1_round_seq against a full-message-schedule SHA-1 model.
module tb_sha1_round_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha1_round_seq_if bus ();

  sha1_round_seq dut (
    .wb_clk_i (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [159:0] IV_TB = {32'hc3d2e1f0, 32'h10325476, 32'h98badcfe,
                                    32'hefcdab89, 32'h67452301};

  logic [159:0] model_h;

  function automatic logic [159:0] dg(input logic [31:0] h0, h1, h2, h3, h4);
    return {h4, h3, h2, h1, h0};
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook SHA-1 compression with the full 80-word expanded schedule.
  function automatic logic [159:0] compress(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
    for (int i = 16; i < 80; i++) w[i] = rl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96]; e = h[159:128];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);           k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                    k = 32'hca62c1d6; end
      t = rl(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rl(b, 30); b = a; a = t;
    end
    return {h[159:128] + e, h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    model_h = IV_TB;
  endtask

  task automatic start_block(input logic [511:0] m, input logic ch);
    bus.msg_i   = m;
    bus.chain_i = ch;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.msg_i   = rand_block();
    bus.chain_i = 1'($urandom);
    model_h = compress(ch ? model_h : IV_TB, m);
  endtask

  // Waits (bounded) for done after a start; optional busy/round_idx timing checks.
  task automatic wait_done(input string tag, input bit timing, input int rounds_seen);
    int busy_cnt = rounds_seen;
    bit seq_ok = 1'b1;
    int i = rounds_seen;
    while (i < 120 && !bus.done_o) begin
      if (bus.busy_o) busy_cnt++;
      if (i < 80 && bus.round_idx_o !== 7'(i)) seq_ok = 1'b0;
      tick();
      i++;
    end
    chk({tag, ".done"}, 160'(bus.done_o), 160'(1));
    chk({tag, ".digest"}, bus.digest_o, model_h);
    if (timing) begin
      chk({tag, ".busy_cycles"}, 160'(busy_cnt), 160'(81));
      chk({tag, ".round_seq"}, 160'(seq_ok), 160'(1));
      chk({tag, ".busy_after"}, 160'(bus.busy_o), 160'(0));
    end
  endtask

  task automatic run_block(input string tag, input logic [511:0] m, input logic ch, input bit timing);
    start_block(m, ch);
    wait_done(tag, timing, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".digest"}, bus.digest_o, IV_TB);
    chk({tag, ".busy"},   160'(bus.busy_o), 160'(0));
    chk({tag, ".done"},   160'(bus.done_o), 160'(0));
    chk({tag, ".panic"},  160'(bus.panic_o), 160'(0));
    chk({tag, ".round"},  160'(bus.round_idx_o), 160'(0));
  endtask

  logic [511:0] m_empty, m_abc, m_2a, m_2b;
  logic [159:0] d_empty, d_abc, d_two;
  logic [31:0]  two_words [14];

  initial begin
    reset_n     = 1'b0;
    bus.clr_i   = 1'b0;
    bus.start_i = 1'b0;
    bus.chain_i = 1'b0;
    bus.msg_i   = '0;
    model_h     = IV_TB;

    m_empty = '0; m_empty[31:0] = 32'h80000000;
    m_abc   = '0; m_abc[31:0]   = 32'h61626380; m_abc[511:480] = 32'h00000018;
    two_words = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071};
    m_2a = '0;
    for (int i = 0; i < 14; i++) m_2a[32*i +: 32] = two_words[i];
    m_2a[479:448] = 32'h80000000;
    m_2b = '0; m_2b[511:480] = 32'h000001c0;

    d_empty = dg(32'hda39a3ee, 32'h5e6b4b0d, 32'h3255bfef, 32'h95601890, 32'hafd80709);
    d_abc   = dg(32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d);
    d_two   = dg(32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1, 32'hf95129e5, 32'he54670f1);

    tick();
    tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    run_block("empty", m_empty, 1'b0, 1'b0);
    chk("empty.known", bus.digest_o, d_empty);

    run_block("abc", m_abc, 1'b0, 1'b1);
    chk("abc.known", bus.digest_o, d_abc);

    // Back-to-back from DONE: two-block message with chaining on the second block.
    run_block("two_a", m_2a, 1'b0, 1'b0);
    run_block("two_b", m_2b, 1'b1, 1'b1);
    chk("two.known", bus.digest_o, d_two);

    // Stray start at round 40 must flag panic and leave the hash untouched.
    start_block(m_abc, 1'b0);
    for (int i = 0; i < 40; i++) tick();
    chk("panic.round40", 160'(bus.round_idx_o), 160'(40));
    bus.msg_i   = rand_block();
    bus.chain_i = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("panic.set", 160'(bus.panic_o), 160'(1));
    wait_done("panic", 1'b0, 41);
    chk("panic.known", bus.digest_o, d_abc);
    chk("panic.sticky", 160'(bus.panic_o), 160'(1));
    pulse_clr();
    chk_idle_outputs("clr");

    bus.clr_i   = 1'b1;
    bus.start_i = 1'b1;
    bus.msg_i   = m_abc;
    tick();
    bus.clr_i   = 1'b0;
    bus.start_i = 1'b0;
    chk_idle_outputs("clr_start");
    tick();
    chk("clr_start.still_idle", 160'(bus.busy_o), 160'(0));

    // Asynchronous reset in the middle of round 30, checked before the next edge.
    start_block(m_abc, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    chk("areset.round30", 160'(bus.round_idx_o), 160'(30));
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("areset");
    tick();
    reset_n = 1'b1;
    model_h = IV_TB;
    tick();

    run_block("abc2", m_abc, 1'b0, 1'b1);
    chk("abc2.known", bus.digest_o, d_abc);

    // chain=1 right after clr must still start from the IV.
    pulse_clr();
    run_block("chain_after_clr", m_abc, 1'b1, 1'b0);
    chk("chain_after_clr.known", bus.digest_o, d_abc);

    for (int n = 0; n < 8; n++) begin
      if (n == 4) pulse_clr();
      run_block($sformatf("rand%0d", n), rand_block(), 1'($urandom), n[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
